// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and RAM-side signal bundle for mem_port_arbiter
//
// Purpose: groups the two requester handshakes, the single-port RAM port
// (address0/ad0/ce0/we0/q0) and the busy flag of mem_port_arbiter.
// Ports (signals):
//   r0_*/r1_*  req, we, addr, wdata (requester -> arbiter)
//              gnt, rvalid, rdata  (arbiter -> requester)
//   mem_*      address0, ad0, ce0, we0 (arbiter -> RAM); q0 (RAM -> arbiter)
//   busy       access issued this cycle or read in flight
// Modports: master = kernels plus RAM macro side, slave = the arbiter.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          r0_req;
  logic          r0_we;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic          r0_gnt;
  logic          r0_rvalid;
  logic [DW-1:0] r0_rdata;

  logic          r1_req;
  logic          r1_we;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic          r1_gnt;
  logic          r1_rvalid;
  logic [DW-1:0] r1_rdata;

  logic [AW-1:0] mem_address0;
  logic [DW-1:0] mem_ad0;
  logic          mem_ce0;
  logic          mem_we0;
  logic [DW-1:0] mem_q0;
  logic          busy;

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    input  r0_gnt, r0_rvalid, r0_rdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  mem_address0, mem_ad0, mem_ce0, mem_we0,
    output mem_q0,
    input  busy
  );

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    output r0_gnt, r0_rvalid, r0_rdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    output r1_gnt, r1_rvalid, r1_rdata,
    output mem_address0, mem_ad0, mem_ce0, mem_we0,
    input  mem_q0,
    output busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin two-requester arbiter for one single-port RAM
//
// Purpose: shares one single-port RAM between two requesters. At most one
// access is issued per cycle; read data is routed back to the issuer LAT
// cycles after issue (plus one register stage).
// Parameters: AW address width, DW data width, LAT RAM read latency (1..4).
// Ports:
//   sys_clk  clock, all state on the rising edge
//   sys_rst  asynchronous reset, active-high
//   bus      mem_port_arbiter_if.slave (requesters, RAM port, busy)
module mem_port_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  mem_port_arbiter_if.slave   bus
);

  // 1 = requester 1 won most recently; resets to 1 so requester 0 wins the first tie
  logic          last_win;
  logic          gnt0;
  logic          gnt1;
  logic          ce;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] ad;
  logic          rv0;
  logic          rv1;
  logic [DW-1:0] rd0;
  logic [DW-1:0] rd1;

  // Read tracker: stage k is valid during the k-th cycle after issue,
  // so stage LAT lines up with mem_q0.
  logic [LAT:0]  trk_v;
  logic [LAT:0]  trk_id;

  logic          elig0;
  logic          elig1;
  logic          win0;
  logic          win1;
  logic          win_any;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic          issue_rd;

  always_comb begin
    // A requester granted this cycle still holds req; mask it so the same
    // access is not issued twice.
    elig0     = bus.r0_req && !gnt0;
    elig1     = bus.r1_req && !gnt1;
    win0      = elig0 && (!elig1 || last_win);
    win1      = elig1 && (!elig0 || !last_win);
    win_any   = win0 || win1;
    win_we    = win1 ? bus.r1_we    : bus.r0_we;
    win_addr  = win1 ? bus.r1_addr  : bus.r0_addr;
    win_wdata = win1 ? bus.r1_wdata : bus.r0_wdata;
    issue_rd  = win_any && !win_we;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      last_win <= 1'b1;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      ce       <= 1'b0;
      we       <= 1'b0;
      addr     <= '0;
      ad       <= '0;
      trk_v    <= '0;
      trk_id   <= '0;
      rv0      <= 1'b0;
      rv1      <= 1'b0;
      rd0      <= '0;
      rd1      <= '0;
    end else begin
      gnt0 <= win0;
      gnt1 <= win1;
      ce   <= win_any;
      we   <= win_any && win_we;
      if (win_any) begin
        addr     <= win_addr;
        ad       <= win_wdata;
        last_win <= win1;
      end

      trk_v  <= {trk_v[LAT-1:0], issue_rd};
      trk_id <= {trk_id[LAT-1:0], win1};

      rv0 <= trk_v[LAT] && !trk_id[LAT];
      rv1 <= trk_v[LAT] &&  trk_id[LAT];
      if (trk_v[LAT] && !trk_id[LAT]) rd0 <= bus.mem_q0;
      if (trk_v[LAT] &&  trk_id[LAT]) rd1 <= bus.mem_q0;
    end
  end

  assign bus.r0_gnt       = gnt0;
  assign bus.r1_gnt       = gnt1;
  assign bus.r0_rvalid    = rv0;
  assign bus.r1_rvalid    = rv1;
  assign bus.r0_rdata     = rd0;
  assign bus.r1_rdata     = rd1;
  assign bus.mem_address0 = addr;
  assign bus.mem_ad0      = ad;
  assign bus.mem_ce0      = ce;
  assign bus.mem_we0      = we;
  assign bus.busy         = ce || (|trk_v);

endmodule
